// File: rtl/mesi_isc_tb_snoop_resp.sv
// ---------------------------------------------------------------------------
// mesi_isc_tb_snoop_resp
//
// Snoop responder for a ten-line MESI cache model. One bus command is handled
// at a time: it is captured in IDLE, looked up against the line state table,
// optionally stalled on a writeback of a snooped Modified line, and completed
// with a one-cycle ack pulse.
//
// Ports
//   clk            single clock, rising edge
//   rst            asynchronous, active-low reset
//   mbus_cmd_i     0 NOP, 1 WR_BROAD, 2 RD_BROAD, 3 EN_WR, 4 EN_RD, 5-7 illegal
//   mbus_addr_i    line address (lines 0-9 exist, 10-15 are ignored)
//   mbus_shared_i  another cache holds the line (EN_RD only)
//   mbus_ack_o     one-cycle command-complete pulse
//   wb_req_o       writeback request while waiting on a snooped M line
//   wb_addr_o      address of the line being written back
//   wb_ack_i       writeback accepted (only looked at while waiting)
//   busy_o         high whenever a command is in flight
//   cache_state_o  line n state on bits [4n+3:4n]
//   wb_cnt_o       saturating count of completed writebacks
// ---------------------------------------------------------------------------
module mesi_isc_tb_snoop_resp #(
    parameter logic [3:0] ST_M = 4'b1000,
    parameter logic [3:0] ST_E = 4'b0100,
    parameter logic [3:0] ST_S = 4'b0010,
    parameter logic [3:0] ST_I = 4'b0001
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [2:0]  mbus_cmd_i,
    input  logic [3:0]  mbus_addr_i,
    input  logic        mbus_shared_i,
    output logic        mbus_ack_o,
    output logic        wb_req_o,
    output logic [3:0]  wb_addr_o,
    input  logic        wb_ack_i,
    output logic        busy_o,
    output logic [39:0] cache_state_o,
    output logic [7:0]  wb_cnt_o
);

    localparam int          NUM_LINES   = 10;
    localparam logic [2:0]  CMD_NOP     = 3'd0;
    localparam logic [2:0]  CMD_WR_BRD  = 3'd1;
    localparam logic [2:0]  CMD_RD_BRD  = 3'd2;
    localparam logic [2:0]  CMD_EN_WR   = 3'd3;
    localparam logic [2:0]  CMD_EN_RD   = 3'd4;

    typedef enum logic [1:0] {
        S_IDLE    = 2'd0,
        S_LOOKUP  = 2'd1,
        S_WB_WAIT = 2'd2,
        S_ACK     = 2'd3
    } state_t;

    state_t         state_reg, state_next;
    logic [2:0]     cmd_reg;
    logic [3:0]     addr_reg;
    logic           shared_reg;
    logic [7:0]     wb_cnt_reg;

    logic [39:0]    lines_flat;
    logic [3:0]     cur_line;
    logic [3:0]     line_next;
    logic           addr_ok;
    logic           cmd_ok;
    logic           need_wb;
    logic           update_en;
    logic           capture;
    logic [NUM_LINES-1:0] line_we;

    // -----------------------------------------------------------------------
    // Command capture. Once a command is taken, the bus inputs are ignored
    // until the FSM is back in IDLE.
    // -----------------------------------------------------------------------
    assign capture = (state_reg == S_IDLE) && (mbus_cmd_i != CMD_NOP);

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            cmd_reg    <= CMD_NOP;
            addr_reg   <= 4'd0;
            shared_reg <= 1'b0;
        end else if (capture) begin
            cmd_reg    <= mbus_cmd_i;
            addr_reg   <= mbus_addr_i;
            shared_reg <= mbus_shared_i;
        end
    end

    // -----------------------------------------------------------------------
    // Lookup of the captured line. Addresses 10-15 match no line, so they
    // read back as Invalid and never trigger a writeback or an update.
    // -----------------------------------------------------------------------
    assign addr_ok = (addr_reg < 4'(NUM_LINES));
    assign cmd_ok  = (cmd_reg >= CMD_WR_BRD) && (cmd_reg <= CMD_EN_RD);

    always_comb begin
        cur_line = ST_I;
        for (int i = 0; i < NUM_LINES; i++) begin
            if (addr_reg == 4'(i)) begin
                cur_line = lines_flat[4*i +: 4];
            end
        end
    end

    // MESI transition for the captured command.
    always_comb begin
        line_next = cur_line;
        case (cmd_reg)
            CMD_WR_BRD: line_next = ST_I;
            CMD_RD_BRD: begin
                if ((cur_line == ST_M) || (cur_line == ST_E)) begin
                    line_next = ST_S;
                end
            end
            CMD_EN_WR:  line_next = ST_M;
            CMD_EN_RD: begin
                if (cur_line == ST_I) begin
                    line_next = shared_reg ? ST_S : ST_E;
                end
            end
            default:    line_next = cur_line;
        endcase
    end

    // A snoop that hits a Modified line must push the data out first.
    assign need_wb = addr_ok && (cur_line == ST_M) &&
                     ((cmd_reg == CMD_WR_BRD) || (cmd_reg == CMD_RD_BRD));

    // The table is written either directly out of LOOKUP or when the
    // writeback is accepted; never both for the same command.
    assign update_en = addr_ok && cmd_ok &&
                       (((state_reg == S_LOOKUP) && !need_wb) ||
                        ((state_reg == S_WB_WAIT) && wb_ack_i));

    // -----------------------------------------------------------------------
    // Line state table, one register per line.
    // -----------------------------------------------------------------------
    generate
        for (genvar gi = 0; gi < NUM_LINES; gi++) begin : g_line
            logic [3:0] line_reg;

            assign line_we[gi] = update_en && (addr_reg == 4'(gi));

            always_ff @(posedge clk or negedge rst) begin
                if (!rst) begin
                    line_reg <= ST_I;
                end else if (line_we[gi]) begin
                    line_reg <= line_next;
                end
            end

            assign lines_flat[4*gi +: 4] = line_reg;
        end
    endgenerate

    // -----------------------------------------------------------------------
    // Control FSM
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= S_IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            S_IDLE: begin
                if (capture) begin
                    state_next = S_LOOKUP;
                end
            end
            S_LOOKUP: begin
                state_next = need_wb ? S_WB_WAIT : S_ACK;
            end
            S_WB_WAIT: begin
                if (wb_ack_i) begin
                    state_next = S_ACK;
                end
            end
            S_ACK: begin
                state_next = S_IDLE;
            end
            default: begin
                state_next = S_IDLE;
            end
        endcase
    end

    // -----------------------------------------------------------------------
    // Writeback counter; saturates so a long run never wraps to zero.
    // -----------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wb_cnt_reg <= 8'd0;
        end else if ((state_reg == S_WB_WAIT) && wb_ack_i && (wb_cnt_reg != 8'hFF)) begin
            wb_cnt_reg <= wb_cnt_reg + 8'd1;
        end
    end

    // -----------------------------------------------------------------------
    // Outputs are decoded from registered state, so reset clears them at once.
    // -----------------------------------------------------------------------
    assign mbus_ack_o    = (state_reg == S_ACK);
    assign wb_req_o      = (state_reg == S_WB_WAIT);
    assign wb_addr_o     = (state_reg == S_WB_WAIT) ? addr_reg : 4'd0;
    assign busy_o        = (state_reg != S_IDLE);
    assign cache_state_o = lines_flat;
    assign wb_cnt_o      = wb_cnt_reg;

endmodule

// File: tb/tb_mesi_isc_tb_snoop_resp.sv
// ---------------------------------------------------------------------------
// tb_mesi_isc_tb_snoop_resp
//
// Directed bench for the MESI snoop responder. A behavioural model (line
// array, writeback count, expected per-cycle handshake levels) is advanced by
// the stimulus task; one compare process checks every DUT output against it
// on each falling edge. A few literal checks pin the model itself.
// ---------------------------------------------------------------------------
module tb_mesi_isc_tb_snoop_resp;

    localparam logic [3:0] M = 4'b1000;
    localparam logic [3:0] E = 4'b0100;
    localparam logic [3:0] S = 4'b0010;
    localparam logic [3:0] I = 4'b0001;

    logic        clk = 1'b0;
    logic        rst;
    logic [2:0]  mbus_cmd_i;
    logic [3:0]  mbus_addr_i;
    logic        mbus_shared_i;
    logic        mbus_ack_o;
    logic        wb_req_o;
    logic [3:0]  wb_addr_o;
    logic        wb_ack_i;
    logic        busy_o;
    logic [39:0] cache_state_o;
    logic [7:0]  wb_cnt_o;

    mesi_isc_tb_snoop_resp dut (
        .clk           (clk),
        .rst           (rst),
        .mbus_cmd_i    (mbus_cmd_i),
        .mbus_addr_i   (mbus_addr_i),
        .mbus_shared_i (mbus_shared_i),
        .mbus_ack_o    (mbus_ack_o),
        .wb_req_o      (wb_req_o),
        .wb_addr_o     (wb_addr_o),
        .wb_ack_i      (wb_ack_i),
        .busy_o        (busy_o),
        .cache_state_o (cache_state_o),
        .wb_cnt_o      (wb_cnt_o)
    );

    always #5 clk = ~clk;

    int checks   = 0;
    int failures = 0;
    int xact_no  = 0;

    // Model
    logic [3:0] m_line [10];
    int         m_cnt;
    logic       exp_ack, exp_req, exp_busy;
    logic [3:0] exp_wb_addr;
    bit         chk_en = 1'b0;
    bit         seen [10][4];

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] req);
        checks++;
        if (act !== req) begin
            failures++;
            $display("FAIL %s actual=%0h required=%0h (t=%0t)", name, act, req, $time);
        end
    endtask

    function automatic logic [39:0] m_pack();
        logic [39:0] v;
        for (int i = 0; i < 10; i++) v[4*i +: 4] = m_line[i];
        return v;
    endfunction

    task automatic m_reset();
        for (int i = 0; i < 10; i++) m_line[i] = I;
        m_cnt       = 0;
        exp_ack     = 1'b0;
        exp_req     = 1'b0;
        exp_busy    = 1'b0;
        exp_wb_addr = 4'd0;
    endtask

    // MESI rules as listed for each command.
    function automatic logic [3:0] m_next(input logic [2:0] c, input logic [3:0] cur, input bit sh);
        if (c == 3'd1) return I;
        if (c == 3'd2) return (cur == M || cur == E) ? S : cur;
        if (c == 3'd3) return M;
        if (c == 3'd4) return (cur == I) ? (sh ? S : E) : cur;
        return cur;
    endfunction

    // Compare process: every output, every cycle.
    always @(negedge clk) begin
        if (chk_en) begin
            chk("ack",     64'(mbus_ack_o),    64'(exp_ack));
            chk("wb_req",  64'(wb_req_o),      64'(exp_req));
            chk("busy",    64'(busy_o),        64'(exp_busy));
            chk("cache",   64'(cache_state_o), 64'(m_pack()));
            chk("wb_cnt",  64'(wb_cnt_o),      64'(m_cnt));
            if (exp_req || !rst) chk("wb_addr", 64'(wb_addr_o), 64'(exp_wb_addr));
            for (int i = 0; i < 10; i++)
                for (int k = 0; k < 4; k++)
                    if (cache_state_o[4*i +: 4] == (4'b1000 >> k)) seen[i][k] = 1'b1;
        end
    end

    // One bus command. Entered and left at #1 after a rising edge, FSM idle.
    // Inputs are scrambled after capture and wb_ack_i is pulsed during LOOKUP
    // to show both are ignored at those times.
    task automatic xact(input logic [2:0] c, input logic [3:0] a, input bit sh,
                        input int wb_delay, input bit reset_in_wb = 1'b0);
        bit         legal;
        bit         wb;
        logic [3:0] cur;
        legal = (c >= 3'd1) && (c <= 3'd4) && (a < 4'd10);
        cur   = (a < 4'd10) ? m_line[a] : I;
        wb    = legal && (c == 3'd1 || c == 3'd2) && (cur == M);
        xact_no++;
        mbus_cmd_i = c; mbus_addr_i = a; mbus_shared_i = sh;
        @(posedge clk); #1;                       // captured, LOOKUP
        exp_busy = 1'b1;
        mbus_cmd_i = 3'($urandom); mbus_addr_i = 4'($urandom); mbus_shared_i = 1'($urandom);
        wb_ack_i = 1'b1;
        @(posedge clk); #1;
        wb_ack_i = 1'b0;
        if (wb) begin
            exp_req = 1'b1; exp_wb_addr = a;      // WB_WAIT
            if (reset_in_wb) begin
                rst = 1'b0; #1;
                m_reset();
                mbus_cmd_i = 3'd0;
                @(posedge clk); #1;
                @(posedge clk); #1;
                rst = 1'b1;
                $display("xact %0d cmd=%0d addr=%0d aborted by reset", xact_no, c, a);
                return;
            end
            repeat (wb_delay) begin
                @(posedge clk); #1;
            end
            wb_ack_i = 1'b1;
            @(posedge clk); #1;
            wb_ack_i = 1'b0;
            exp_req = 1'b0; exp_wb_addr = 4'd0;
            m_cnt = (m_cnt < 255) ? m_cnt + 1 : 255;
        end
        if (legal) m_line[a] = m_next(c, cur, sh);
        exp_ack = 1'b1;                           // ACK
        @(posedge clk); #1;                       // back in IDLE
        exp_ack = 1'b0; exp_busy = 1'b0;
        mbus_cmd_i = 3'd0;
        $display("xact %0d cmd=%0d addr=%0d sh=%0d wb=%0d line=%b cnt=%0d",
                 xact_no, c, a, sh, wb, (a < 4'd10) ? m_line[a] : 4'bxxxx, m_cnt);
    endtask

    initial begin
        rst = 1'b0; mbus_cmd_i = 3'd0; mbus_addr_i = 4'd0; mbus_shared_i = 1'b0; wb_ack_i = 1'b0;
        m_reset();
        repeat (2) @(posedge clk);
        #1;
        chk_en = 1'b1;
        chk("reset_cache", 64'(cache_state_o), 64'(40'h11_1111_1111));
        chk("reset_busy",  64'(busy_o), 64'd0);
        rst = 1'b1;

        // EN_RD line 3, not shared -> Exclusive.
        xact(3'd4, 4'd3, 1'b0, 0);
        chk("line3_E", 64'(cache_state_o[15:12]), 64'(4'b0100));

        // EN_WR line 5 then snooped read with a 10-cycle writeback stall.
        xact(3'd3, 4'd5, 1'b0, 0);
        xact(3'd2, 4'd5, 1'b0, 10);
        chk("line5_S", 64'(cache_state_o[23:20]), 64'(4'b0010));
        chk("cnt_1",   64'(wb_cnt_o), 64'd1);

        // EN_RD shared line 7, then WR_BROAD without writeback.
        xact(3'd4, 4'd7, 1'b1, 0);
        chk("line7_S", 64'(cache_state_o[31:28]), 64'(4'b0010));
        xact(3'd1, 4'd7, 1'b0, 0);
        chk("line7_I", 64'(cache_state_o[31:28]), 64'(4'b0001));

        // Nonexistent line and illegal command: no change, normal ack.
        xact(3'd1, 4'd12, 1'b0, 0);
        xact(3'd6, 4'd2, 1'b0, 0);
        xact(3'd3, 4'd15, 1'b0, 0);

        // Walk every line through I, E, S, M.
        for (int a = 0; a < 10; a++) begin
            xact(3'd1, 4'(a), 1'b0, 0);
            xact(3'd4, 4'(a), 1'b0, 0);
            xact(3'd2, 4'(a), 1'b0, 0);
            xact(3'd3, 4'(a), 1'b0, 0);
        end
        // Lines are all M now; EN_RD and EN_WR must leave them as they are.
        xact(3'd4, 4'd4, 1'b1, 0);
        xact(3'd3, 4'd4, 1'b0, 0);

        // Reset during WB_WAIT aborts with nothing recorded.
        xact(3'd3, 4'd0, 1'b0, 0);
        xact(3'd1, 4'd0, 1'b0, 3, 1'b1);
        chk("abort_cache", 64'(cache_state_o), 64'(40'h11_1111_1111));
        chk("abort_cnt",   64'(wb_cnt_o), 64'd0);

        // 300 writebacks to drive the counter into saturation.
        for (int n = 0; n < 300; n++) begin
            xact(3'd3, 4'(n % 10), 1'b0, 0);
            xact((n % 2 == 0) ? 3'd2 : 3'd1, 4'(n % 10), 1'b0, n % 3);
        end
        chk("cnt_sat", 64'(wb_cnt_o), 64'd255);

        for (int i = 0; i < 10; i++)
            for (int k = 0; k < 4; k++)
                chk($sformatf("cover_l%0d_s%0d", i, k), 64'(seen[i][k]), 64'd1);

        @(negedge clk);
        chk_en = 1'b0;
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    // Guard against a hang; every wait in the bench is bounded by cycle count,
    // this only trips if simulation time runs away.
    initial begin
        #2_000_000;
        $display("FAIL timeout actual=running required=finished");
        $fatal(1);
    end

endmodule
